// File: rtl/atm_session_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : atm_session_ctrl_if
// Brief    : Host-side bundle for atm_session_ctrl: table programming, login,
//            command handshake, forced exit and session status outputs.
// Revision : 1.0
// ============================================================================
interface atm_session_ctrl_if #(
    parameter int NUM_ACCTS = 10,
    parameter int ACC_W     = 12,
    parameter int PIN_W     = 4,
    parameter int BAL_W     = 16,
    parameter int AMT_W     = 11
);
    localparam int IW = $clog2(NUM_ACCTS);

    logic             prog_we;
    logic [IW-1:0]    prog_idx;
    logic [ACC_W-1:0] prog_acc;
    logic [PIN_W-1:0] prog_pin;
    logic [BAL_W-1:0] prog_bal;

    logic             login_req;
    logic [ACC_W-1:0] login_acc;
    logic [PIN_W-1:0] login_pin;

    logic             cmd_valid;
    logic [2:0]       cmd_op;
    logic [AMT_W-1:0] cmd_amt;
    logic [ACC_W-1:0] cmd_dest;
    logic             exit;

    logic             cmd_ready;
    logic             logged_in;
    logic             done;
    logic             error;
    logic [2:0]       err_code;
    logic [BAL_W-1:0] balance;

    modport master (
        output prog_we, prog_idx, prog_acc, prog_pin, prog_bal,
        output login_req, login_acc, login_pin,
        output cmd_valid, cmd_op, cmd_amt, cmd_dest, exit,
        input  cmd_ready, logged_in, done, error, err_code, balance
    );

    modport slave (
        input  prog_we, prog_idx, prog_acc, prog_pin, prog_bal,
        input  login_req, login_acc, login_pin,
        input  cmd_valid, cmd_op, cmd_amt, cmd_dest, exit,
        output cmd_ready, logged_in, done, error, err_code, balance
    );
endinterface
`default_nettype wire

// File: rtl/atm_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : atm_session_ctrl
// Brief    : ATM session controller with an account table, sequential
//            credential/destination scan, PIN lockout and idle timeout.
// Revision : 1.0
// ============================================================================
module atm_session_ctrl #(
    parameter int NUM_ACCTS   = 10,
    parameter int ACC_W       = 12,
    parameter int PIN_W       = 4,
    parameter int BAL_W       = 16,
    parameter int AMT_W       = 11,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 6000
) (
    input  logic              clk,
    input  logic              rst,
    atm_session_ctrl_if.slave bus
);
    localparam int IW = $clog2(NUM_ACCTS);
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_ACCTS - 1);
    localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYC - 1);
    localparam logic [FW-1:0] TRY_LIMIT  = FW'(MAX_TRIES);

    localparam logic [2:0] OP_BAL    = 3'd0;
    localparam logic [2:0] OP_WD     = 3'd1;
    localparam logic [2:0] OP_DEP    = 3'd2;
    localparam logic [2:0] OP_XFER   = 3'd3;
    localparam logic [2:0] OP_LOGOUT = 3'd4;

    localparam logic [2:0] ERR_OK     = 3'd0;
    localparam logic [2:0] ERR_CRED   = 3'd1;
    localparam logic [2:0] ERR_LOCKED = 3'd2;
    localparam logic [2:0] ERR_FUNDS  = 3'd3;
    localparam logic [2:0] ERR_OVF    = 3'd4;
    localparam logic [2:0] ERR_DEST   = 3'd5;
    localparam logic [2:0] ERR_OP     = 3'd6;
    localparam logic [2:0] ERR_ABORT  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SCAN_LOGIN = 3'd1,
        S_MENU       = 3'd2,
        S_EXEC       = 3'd3,
        S_SCAN_DEST  = 3'd4,
        S_FINISH     = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [ACC_W-1:0] acc_q  [NUM_ACCTS];
    logic [ACC_W-1:0] acc_d  [NUM_ACCTS];
    logic [PIN_W-1:0] pin_q  [NUM_ACCTS];
    logic [PIN_W-1:0] pin_d  [NUM_ACCTS];
    logic [BAL_W-1:0] bal_q  [NUM_ACCTS];
    logic [BAL_W-1:0] bal_d  [NUM_ACCTS];
    logic [FW-1:0]    fail_q [NUM_ACCTS];
    logic [FW-1:0]    fail_d [NUM_ACCTS];
    logic             vld_q  [NUM_ACCTS];
    logic             vld_d  [NUM_ACCTS];
    logic             lock_q [NUM_ACCTS];
    logic             lock_d [NUM_ACCTS];

    logic [ACC_W-1:0] lacc_q, lacc_d;
    logic [PIN_W-1:0] lpin_q, lpin_d;
    logic [2:0]       op_q, op_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic [ACC_W-1:0] dest_q, dest_d;
    logic [IW-1:0]    scan_idx_q, scan_idx_d;
    logic             match_q, match_d;
    logic [IW-1:0]    match_idx_q, match_idx_d;
    logic [IW-1:0]    sess_idx_q, sess_idx_d;
    logic [TW-1:0]    idle_q, idle_d;

    logic             cmd_ready_q, cmd_ready_d;
    logic             logged_in_q, logged_in_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [2:0]       err_code_q, err_code_d;
    logic [BAL_W-1:0] balance_q, balance_d;

    // Shared scan datapath: the key depends on whether we look up a login or a destination.
    logic [ACC_W-1:0] scan_key;
    logic             scan_hit;
    logic             scan_found;
    logic [IW-1:0]    scan_fidx;
    logic [FW-1:0]    fail_inc;
    logic [BAL_W-1:0] own_bal;
    logic [BAL_W-1:0] amt_ext;
    logic [BAL_W:0]   dep_sum;
    logic [BAL_W:0]   xfer_sum;

    assign scan_key   = (state_q == S_SCAN_DEST) ? dest_q : lacc_q;
    assign scan_hit   = vld_q[scan_idx_q] && (acc_q[scan_idx_q] == scan_key);
    assign scan_found = match_q || scan_hit;
    assign scan_fidx  = match_q ? match_idx_q : scan_idx_q;
    assign fail_inc   = fail_q[scan_fidx] + 1'b1;
    assign own_bal    = bal_q[sess_idx_q];
    assign amt_ext    = {{(BAL_W - AMT_W){1'b0}}, amt_q};
    assign dep_sum    = {1'b0, own_bal} + {1'b0, amt_ext};
    assign xfer_sum   = {1'b0, bal_q[match_idx_q]} + {1'b0, amt_ext};

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        pin_d       = pin_q;
        bal_d       = bal_q;
        fail_d      = fail_q;
        vld_d       = vld_q;
        lock_d      = lock_q;
        lacc_d      = lacc_q;
        lpin_d      = lpin_q;
        op_d        = op_q;
        amt_d       = amt_q;
        dest_d      = dest_q;
        scan_idx_d  = scan_idx_q;
        match_d     = match_q;
        match_idx_d = match_idx_q;
        sess_idx_d  = sess_idx_q;
        idle_d      = idle_q;
        cmd_ready_d = cmd_ready_q;
        logged_in_d = logged_in_q;
        balance_d   = balance_q;
        done_d      = 1'b0;
        err_code_d  = ERR_OK;

        // Forced exit pre-empts every other transition, so no table write can slip through.
        if ((state_q != S_IDLE) && bus.exit) begin
            state_d     = S_IDLE;
            logged_in_d = 1'b0;
            cmd_ready_d = 1'b0;
            done_d      = 1'b1;
            err_code_d  = ERR_ABORT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.prog_we && (32'(bus.prog_idx) < 32'(NUM_ACCTS))) begin
                        acc_d[bus.prog_idx]  = bus.prog_acc;
                        pin_d[bus.prog_idx]  = bus.prog_pin;
                        bal_d[bus.prog_idx]  = bus.prog_bal;
                        vld_d[bus.prog_idx]  = 1'b1;
                        fail_d[bus.prog_idx] = '0;
                        lock_d[bus.prog_idx] = 1'b0;
                    end
                    if (bus.login_req) begin
                        lacc_d      = bus.login_acc;
                        lpin_d      = bus.login_pin;
                        scan_idx_d  = '0;
                        match_d     = 1'b0;
                        match_idx_d = '0;
                        state_d     = S_SCAN_LOGIN;
                    end
                end

                S_SCAN_LOGIN: begin
                    if (scan_idx_q != LAST_IDX) begin
                        scan_idx_d  = scan_idx_q + 1'b1;
                        match_d     = scan_found;
                        match_idx_d = scan_fidx;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        if (!scan_found) begin
                            err_code_d = ERR_CRED;
                        end else if (lock_q[scan_fidx]) begin
                            err_code_d = ERR_LOCKED;
                        end else if (pin_q[scan_fidx] != lpin_q) begin
                            err_code_d        = ERR_CRED;
                            fail_d[scan_fidx] = fail_inc;
                            if (fail_inc >= TRY_LIMIT) begin
                                lock_d[scan_fidx] = 1'b1;
                            end
                        end else begin
                            fail_d[scan_fidx] = '0;
                            sess_idx_d        = scan_fidx;
                            balance_d         = bal_q[scan_fidx];
                            logged_in_d       = 1'b1;
                            cmd_ready_d       = 1'b1;
                            idle_d            = '0;
                            state_d           = S_MENU;
                        end
                    end
                end

                S_MENU: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        op_d        = bus.cmd_op;
                        amt_d       = bus.cmd_amt;
                        dest_d      = bus.cmd_dest;
                        cmd_ready_d = 1'b0;
                        idle_d      = '0;
                        if (bus.cmd_op == OP_XFER) begin
                            scan_idx_d  = '0;
                            match_d     = 1'b0;
                            match_idx_d = '0;
                            state_d     = S_SCAN_DEST;
                        end else begin
                            state_d = S_EXEC;
                        end
                    end else if (idle_q == IDLE_LIMIT) begin
                        state_d     = S_IDLE;
                        logged_in_d = 1'b0;
                        cmd_ready_d = 1'b0;
                        done_d      = 1'b1;
                        err_code_d  = ERR_ABORT;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end

                S_EXEC: begin
                    done_d      = 1'b1;
                    cmd_ready_d = 1'b1;
                    state_d     = S_MENU;
                    case (op_q)
                        OP_BAL: balance_d = own_bal;
                        OP_WD: begin
                            if (amt_ext > own_bal) begin
                                err_code_d = ERR_FUNDS;
                            end else begin
                                bal_d[sess_idx_q] = own_bal - amt_ext;
                                balance_d         = own_bal - amt_ext;
                            end
                        end
                        OP_DEP: begin
                            if (dep_sum[BAL_W]) begin
                                err_code_d = ERR_OVF;
                            end else begin
                                bal_d[sess_idx_q] = dep_sum[BAL_W-1:0];
                                balance_d         = dep_sum[BAL_W-1:0];
                            end
                        end
                        OP_LOGOUT: begin
                            logged_in_d = 1'b0;
                            cmd_ready_d = 1'b0;
                            state_d     = S_IDLE;
                        end
                        default: err_code_d = ERR_OP;
                    endcase
                end

                S_SCAN_DEST: begin
                    match_d     = scan_found;
                    match_idx_d = scan_fidx;
                    if (scan_idx_q != LAST_IDX) begin
                        scan_idx_d = scan_idx_q + 1'b1;
                    end else begin
                        state_d = S_FINISH;
                    end
                end

                S_FINISH: begin
                    done_d      = 1'b1;
                    cmd_ready_d = 1'b1;
                    state_d     = S_MENU;
                    if (!match_q || (match_idx_q == sess_idx_q) || (dest_q == acc_q[sess_idx_q])) begin
                        err_code_d = ERR_DEST;
                    end else if (amt_ext > own_bal) begin
                        err_code_d = ERR_FUNDS;
                    end else if (xfer_sum[BAL_W]) begin
                        err_code_d = ERR_OVF;
                    end else begin
                        bal_d[sess_idx_q]  = own_bal - amt_ext;
                        bal_d[match_idx_q] = xfer_sum[BAL_W-1:0];
                        balance_d          = own_bal - amt_ext;
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end

        error_d = (err_code_d != ERR_OK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '{default: '0};
            pin_q       <= '{default: '0};
            bal_q       <= '{default: '0};
            fail_q      <= '{default: '0};
            vld_q       <= '{default: 1'b0};
            lock_q      <= '{default: 1'b0};
            lacc_q      <= '0;
            lpin_q      <= '0;
            op_q        <= '0;
            amt_q       <= '0;
            dest_q      <= '0;
            scan_idx_q  <= '0;
            match_q     <= 1'b0;
            match_idx_q <= '0;
            sess_idx_q  <= '0;
            idle_q      <= '0;
            cmd_ready_q <= 1'b0;
            logged_in_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= '0;
            balance_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            pin_q       <= pin_d;
            bal_q       <= bal_d;
            fail_q      <= fail_d;
            vld_q       <= vld_d;
            lock_q      <= lock_d;
            lacc_q      <= lacc_d;
            lpin_q      <= lpin_d;
            op_q        <= op_d;
            amt_q       <= amt_d;
            dest_q      <= dest_d;
            scan_idx_q  <= scan_idx_d;
            match_q     <= match_d;
            match_idx_q <= match_idx_d;
            sess_idx_q  <= sess_idx_d;
            idle_q      <= idle_d;
            cmd_ready_q <= cmd_ready_d;
            logged_in_q <= logged_in_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
            balance_q   <= balance_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.logged_in = logged_in_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.err_code  = err_code_q;
    assign bus.balance   = balance_q;

endmodule
`default_nettype wire
